// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory request/response, execute redirect
// and the buffered instruction handed to decode.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem read, one-entry output
// buffer towards decode, and PC redirect with flush of the in-flight fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        discard;
    logic        discard_next;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        req_valid;
    logic        rsp_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_REQ;
            discard <= 1'b0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    // Only one read is ever outstanding; a redirect while waiting marks it to be dropped.
    always_comb begin
        state_next   = state;
        discard_next = discard;
        req_valid    = 1'b0;
        case (state)
            S_REQ: begin
                req_valid = !rst && !bus.redirect_valid && (!inst_valid || bus.inst_ready);
                if (req_valid && bus.imem_req_ready)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_next   = S_REQ;
                    discard_next = 1'b0;
                end else if (bus.redirect_valid) begin
                    discard_next = 1'b1;
                end
            end
        endcase
    end

    assign rsp_take = (state == S_WAIT) && bus.imem_rsp_valid && !discard && !bus.redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= PC_INIT;
            inst_valid  <= 1'b0;
            instruction <= NOP;
            inst_pc     <= PC_INIT;
        end else if (bus.redirect_valid) begin
            pc         <= {bus.redirect_pc[31:2], 2'b00};
            inst_valid <= 1'b0;
        end else if (rsp_take) begin
            instruction <= bus.imem_rsp_data;
            inst_pc     <= pc;
            inst_valid  <= 1'b1;
            pc          <= pc + 32'd4;
        end else if (inst_valid && bus.inst_ready) begin
            inst_valid <= 1'b0;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = inst_valid;
    assign bus.instruction    = instruction;
    assign bus.inst_pc        = inst_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level reference model
// of the fetch stream, plus a second instance checking PC wrap from the top of memory.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_hi = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if b ();
    fetch_unit_if hb ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(b.master));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (.clk(clk), .rst(rst_hi), .bus(hb.master));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0: return 32'h0000_0103;
            1: return 32'hFFFF_FFF9;
            2: return $urandom;
            default: return 32'h0000_0010;
        endcase
    endfunction

    // Reference model: the stream of fetches in flight and what decode should see.
    typedef struct {
        logic [31:0] addr;
        bit          live;
    } fetch_t;
    fetch_t      inflight[$];
    logic [31:0] m_pc;
    bit          m_buf_v;
    logic [31:0] m_buf_word;
    logic [31:0] m_buf_pc;

    // Memory environment.
    bit          mem_busy;
    int unsigned mem_wait;
    int unsigned mem_max_wait;
    logic [31:0] mem_addr;

    task automatic model_reset();
        inflight.delete();
        m_pc     = 32'h0;
        m_buf_v  = 0;
        mem_busy = 0;
        mem_wait = 0;
    endtask

    task automatic cycle(input int unsigned p_ready, input int unsigned p_iready,
                         input int unsigned p_redir, input int unsigned p_spur);
        bit          exp_req;
        bit          fire;
        logic [31:0] fire_addr;
        fetch_t      f;
        b.imem_req_ready = ($urandom_range(99) < p_ready);
        b.inst_ready     = ($urandom_range(99) < p_iready);
        b.redirect_valid = ($urandom_range(99) < p_redir);
        b.redirect_pc    = pick_target();
        if (mem_busy && mem_wait == 0) begin
            b.imem_rsp_valid = 1'b1;
            b.imem_rsp_data  = mem_fn(mem_addr);
        end else begin
            b.imem_rsp_valid = !mem_busy && ($urandom_range(99) < p_spur);
            b.imem_rsp_data  = $urandom;
        end
        #1;
        exp_req = (inflight.size() == 0) && !b.redirect_valid && (!m_buf_v || b.inst_ready);
        check("req_valid", {31'b0, b.imem_req_valid}, {31'b0, exp_req});
        if (exp_req) check("req_addr", b.imem_req_addr, m_pc);
        check("inst_valid", {31'b0, b.inst_valid}, {31'b0, m_buf_v});
        if (m_buf_v) begin
            check("instruction", b.instruction, m_buf_word);
            check("inst_pc", b.inst_pc, m_buf_pc);
        end
        // memory side follows what the DUT actually presents
        if (mem_busy && b.imem_rsp_valid) mem_busy = 0;
        else if (mem_busy) mem_wait--;
        if (b.imem_req_valid && b.imem_req_ready && !mem_busy) begin
            mem_busy = 1;
            mem_addr = b.imem_req_addr;
            mem_wait = $urandom_range(mem_max_wait);
        end
        // reference model update
        fire      = exp_req && b.imem_req_ready;
        fire_addr = m_pc;
        if (b.redirect_valid) begin
            foreach (inflight[i]) inflight[i].live = 0;
            m_pc    = b.redirect_pc & ~32'd3;
            m_buf_v = 0;
        end else if (m_buf_v && b.inst_ready) begin
            m_buf_v = 0;
        end
        if (inflight.size() != 0 && b.imem_rsp_valid) begin
            f = inflight.pop_front();
            if (f.live) begin
                m_buf_v    = 1;
                m_buf_word = mem_fn(f.addr);
                m_buf_pc   = f.addr;
                m_pc       = f.addr + 32'd4;
            end
        end
        if (fire) inflight.push_back('{fire_addr, 1'b1});
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, b.imem_req_valid}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, b.inst_valid}, 32'd0);
        check({tag, "_instruction"}, b.instruction, NOP);
        check({tag, "_inst_pc"}, b.inst_pc, 32'h0);
    endtask

    initial begin
        int          waited;
        bit          hi_pend;
        logic [31:0] hi_addr;
        logic [31:0] hi_exp_pc;
        bit          hi_exp_v;

        b.imem_req_ready  = 0;
        b.imem_rsp_valid  = 0;
        b.imem_rsp_data   = 0;
        b.redirect_valid  = 0;
        b.redirect_pc     = 0;
        b.inst_ready      = 0;
        hb.imem_req_ready = 1;
        hb.imem_rsp_valid = 0;
        hb.imem_rsp_data  = 0;
        hb.redirect_valid = 0;
        hb.redirect_pc    = 0;
        hb.inst_ready     = 1;
        model_reset();
        mem_max_wait = 0;

        #12;
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst = 0;

        // zero-wait memory, decode always ready: 0,4,8,... every second cycle
        for (int i = 0; i < 10; i++) cycle(100, 100, 0, 0);

        mem_max_wait = 2;
        for (int i = 0; i < 1500; i++) cycle(70, 60, 8, 10);

        // async reset landing between edges while a read is outstanding
        waited = 0;
        while (inflight.size() == 0 && waited < 50) begin
            cycle(100, 100, 0, 0);
            waited++;
        end
        check("wait_pending_timeout", {31'b0, (inflight.size() != 0)}, 32'd1);
        b.imem_rsp_valid = 0;
        b.redirect_valid = 0;
        #2;
        rst = 1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 0;
        model_reset();
        mem_max_wait = 0;
        for (int i = 0; i < 20; i++) cycle(100, 100, 0, 0);

        mem_max_wait = 2;
        for (int i = 0; i < 500; i++) cycle(80, 70, 30, 10);

        // second instance: PC wraps from 0xFFFF_FFFC to 0
        check("hi_rst_inst_pc", hb.inst_pc, 32'hFFFF_FFFC);
        check("hi_rst_instruction", hb.instruction, NOP);
        check("hi_rst_inst_valid", {31'b0, hb.inst_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_hi  = 0;
        hi_pend = 0;
        hi_addr = 32'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            hb.imem_rsp_valid = hi_pend;
            hb.imem_rsp_data  = hi_pend ? mem_fn(hi_addr) : 32'hDEAD_BEEF;
            #1;
            hi_exp_v  = (cyc >= 2) && (cyc % 2 == 0);
            hi_exp_pc = 32'hFFFF_FFFC + 32'(4 * ((cyc - 2) / 2));
            check("hi_inst_valid", {31'b0, hb.inst_valid}, {31'b0, hi_exp_v});
            if (hi_exp_v) begin
                check("hi_inst_pc", hb.inst_pc, hi_exp_pc);
                check("hi_instruction", hb.instruction, mem_fn(hi_exp_pc));
            end
            hi_pend = hb.imem_req_valid;
            if (hb.imem_req_valid) hi_addr = hb.imem_req_addr;
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
